// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front-end bundle: imem request/response, redirect, decode handshake
interface fetch_queue_if;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
        input  redirect_valid, redirect_pc,
        output id_valid, id_inst, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
        output redirect_valid, redirect_pc,
        input  id_valid, id_inst, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC, credit-limited imem requests, PC/inst FIFO toward decode
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic [CW:0]   credit_used;
    logic [63:0]   redirect_target;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Every outstanding request owns a FIFO slot, so responses can never overflow the queue.
    assign credit_used     = {1'b0, inflight} + {1'b0, count};
    assign redirect_target = bus.redirect_pc & ~64'h3;

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign push = bus.imem_resp_valid && !bus.redirect_valid && (drop == '0);

    assign bus.id_valid = (count != '0) && !bus.redirect_valid;
    assign bus.id_inst  = reset ? 32'h0 : inst_mem[rd_ptr];
    assign bus.id_pc    = reset ? 64'h0 : pc_mem[rd_ptr];
    assign pop          = bus.id_valid && bus.id_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            // A response landing in the redirect cycle is already stale and is absorbed here.
            fetch_pc <= redirect_target;
            resp_pc  <= redirect_target;
            count    <= '0;
            rd_ptr   <= wr_ptr;
            inflight <= inflight - CW'(bus.imem_resp_valid);
            drop     <= inflight - CW'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            inflight <= inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (bus.imem_resp_valid && (drop != '0)) begin
                drop <= drop - 1'b1;
            end
            if (push) begin
                resp_pc <= resp_pc + 64'd4;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.imem_resp_inst;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CW'(DEPTH))));
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(bus.imem_resp_valid && (inflight == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with an in-order latency memory model
module tb_fetch_queue;
    logic clk;
    logic reset;
    fetch_queue_if bus();

    fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;
    int n_fire = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;
    int rel_cyc = 0;

    logic [63:0] exp_pc_q [$];
    logic [63:0] pend_addr [$];
    int          pend_due  [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Memory model: responses in request order, lat cycles after acceptance, cleared by reset.
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                bus.imem_resp_valid = 1'b0;
                n_fire = 0;
            end else begin
                if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_inst  = inst_of(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.imem_resp_valid = 1'b0;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend_addr.push_back(bus.imem_req_addr);
                    pend_due.push_back(cyc + lat);
                    n_fire++;
                end
            end
        end
    end

    // Monitor: every decode handshake pops the scoreboard and is compared.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                if (bus.redirect_valid) begin
                    chk("id_valid_during_redirect", {63'h0, bus.id_valid}, 64'h0);
                    chk("req_valid_during_redirect", {63'h0, bus.imem_req_valid}, 64'h0);
                end
                if (bus.id_valid && bus.id_ready) begin
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    if (exp_pc_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pop: got pc %h want no delivery", bus.id_pc);
                    end else begin
                        logic [63:0] e;
                        e = exp_pc_q.pop_front();
                        chk("id_pc", bus.id_pc, e);
                        chk("id_inst", {32'h0, bus.id_inst}, {32'h0, inst_of(e)});
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #4;
        rel_cyc = cyc;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_pc_q.size() == 0) break;
        end
        bus.id_ready = 1'b0;
        n_cmp++;
        if (exp_pc_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d undelivered want 0", name, exp_pc_q.size());
            exp_pc_q.delete();
        end
    endtask

    task automatic redirect(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.id_ready       = 1'b0;
        #12;
        chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("rst_id_valid", {63'h0, bus.id_valid}, 64'h0);
        chk("rst_id_inst", {32'h0, bus.id_inst}, 64'h0);
        chk("rst_id_pc", bus.id_pc, 64'h0);

        // 1: streaming at one instruction per cycle after a two-cycle fill
        lat = 1;
        do_reset();
        for (int i = 0; i < 12; i++) exp_pc_q.push_back(64'(i * 4));
        first_pop_cyc = -1;
        bus.id_ready = 1'b1;
        wait_empty("t1", 40);
        chk("t1_first_pop_cycle", 64'(first_pop_cyc - rel_cyc), 64'd2);
        chk("t1_last_pop_cycle", 64'(last_pop_cyc - rel_cyc), 64'd13);

        // 2: decode stalled, credits cap requests at DEPTH
        do_reset();
        repeat (10) @(negedge clk);
        #3;
        chk("t2_fires", 64'(n_fire), 64'd4);
        chk("t2_count", 64'(dut.count), 64'd4);
        chk("t2_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        exp_pc_q.push_back(64'h0);
        exp_pc_q.push_back(64'h4);
        exp_pc_q.push_back(64'h8);
        exp_pc_q.push_back(64'hC);
        @(negedge clk);
        bus.id_ready = 1'b1;
        wait_empty("t2", 20);

        // 3: long latency, redirect with two requests outstanding
        lat = 3;
        do_reset();
        bus.id_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_inflight", 64'(dut.inflight), 64'd2);
        for (int i = 0; i < 4; i++) exp_pc_q.push_back(64'h100 + 64'(i * 4));
        redirect(64'h100);
        #1;
        chk("t3_drop", 64'(dut.drop), 64'd2);
        wait_empty("t3", 40);

        // 4: redirect collides with a response and a pop; unaligned target
        lat = 1;
        do_reset();
        exp_pc_q.push_back(64'h0);
        exp_pc_q.push_back(64'h4);
        bus.id_ready = 1'b1;
        repeat (4) @(negedge clk);
        redirect(64'h403);
        #4;
        chk("t4_empty_after", {63'h0, bus.id_valid}, 64'h0);
        chk("t4_count", 64'(dut.count), 64'd0);
        chk("t4_scoreboard_drained", 64'(exp_pc_q.size()), 64'd0);
        chk("t4_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("t4_req_addr", bus.imem_req_addr, 64'h400);
        exp_pc_q.push_back(64'h400);
        exp_pc_q.push_back(64'h404);
        wait_empty("t4", 20);

        // 5: back-to-back redirects, the later target wins
        repeat (6) @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h200;
        @(negedge clk);
        redirect(64'h300);
        exp_pc_q.push_back(64'h300);
        exp_pc_q.push_back(64'h304);
        exp_pc_q.push_back(64'h308);
        bus.id_ready = 1'b1;
        wait_empty("t5", 20);

        // 6: reset with three entries buffered
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("t6_count_before", 64'(dut.count), 64'd3);
        chk("t6_id_valid_before", {63'h0, bus.id_valid}, 64'h1);
        reset = 1'b1;
        #1;
        chk("t6_id_valid_in_reset", {63'h0, bus.id_valid}, 64'h0);
        chk("t6_req_valid_in_reset", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("t6_id_pc_in_reset", bus.id_pc, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_req_valid_after", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("t6_req_addr_after", bus.imem_req_addr, 64'h0);
        exp_pc_q.push_back(64'h0);
        exp_pc_q.push_back(64'h4);
        @(negedge clk);
        bus.id_ready = 1'b1;
        wait_empty("t6", 20);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
